// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, types and the key sequencer FSM encoding
// Purpose : common definitions for the decrypt-side round-key sequencer.
// Contents: NR / STATE_W constants, state and round-index types, seq_state_e.
package aes_pkg;

   localparam int NR      = 10;
   localparam int STATE_W = 128;

   typedef logic [STATE_W-1:0] state_t;
   typedef logic [3:0]         round_idx_t;

   // EMPTY  : collecting round keys in expansion order
   // LOADED : all NR+1 keys present, waiting for start
   // RUN    : replaying keys NR..0 onto incoming state beats
   typedef enum logic [1:0] {
      EMPTY,
      LOADED,
      RUN
   } seq_state_e;

endpackage

// File: rtl/addRoundKey.sv
// rtl/addRoundKey.sv - AddRoundKey XOR stage
// Purpose : combinational XOR of a cipher state with one round key.
// Ports   : i_state (state in), i_key (round key), o_state (state ^ key).
module addRoundKey #(
   parameter int WIDTH = 128
) (
   input  logic [WIDTH-1:0] i_state,
   input  logic [WIDTH-1:0] i_key,
   output logic [WIDTH-1:0] o_state
);

   assign o_state = i_state ^ i_key;

endmodule

// File: rtl/inv_round_key_sequencer.sv
// rtl/inv_round_key_sequencer.sv - decrypt-side round-key buffer and reverse-order AddRoundKey
// Purpose : stores NR+1 round keys written in expansion order, then on start
//           XORs them in reverse order (NR..0) onto a stream of state beats.
// Ports   : clk, rst (async, active-high)
//           key_wr_en / key_wr_data / key_clear / keys_loaded - key buffer fill
//           start / busy                                      - sequence control
//           in_valid / in_ready / in_data                     - state input
//           out_valid / out_ready / out_data / out_round / out_last - XORed output
module inv_round_key_sequencer #(
   parameter int WIDTH = aes_pkg::STATE_W,
   parameter int NR    = aes_pkg::NR
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_wr_en,
   input  logic [WIDTH-1:0]           key_wr_data,
   input  logic                       key_clear,
   output logic                       keys_loaded,
   input  logic                       start,
   output logic                       busy,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(NR+1)-1:0]    out_round,
   output logic                       out_last
);

   import aes_pkg::*;

   localparam int RW = $clog2(NR+1);

   seq_state_e       r_state;
   logic [WIDTH-1:0] r_key [0:NR];
   logic [RW-1:0]    r_wr_ptr;
   logic [RW-1:0]    r_rd_round;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [RW-1:0]    r_out_round;
   logic             r_out_last;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_key_we;
   logic [WIDTH-1:0] w_xor;

   // Accept a new beat whenever the output slot is empty or being drained.
   assign w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
   assign w_accept   = w_in_ready && in_valid;
   // Writes only land while filling; clear drops a coincident write.
   assign w_key_we   = (r_state == EMPTY) && key_wr_en && !key_clear;

   addRoundKey #(.WIDTH(WIDTH)) u_add_round_key (
      .i_state (in_data),
      .i_key   (r_key[r_rd_round]),
      .o_state (w_xor)
   );

   always_ff @(posedge clk) begin
      if (w_key_we) begin
         r_key[r_wr_ptr] <= key_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_wr_ptr    <= '0;
         r_rd_round  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_round <= '0;
         r_out_last  <= 1'b0;
      end else if (key_clear) begin
         r_state     <= EMPTY;
         r_wr_ptr    <= '0;
         r_rd_round  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_xor;
            r_out_round <= r_rd_round;
            r_out_last  <= (r_rd_round == '0);
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            EMPTY: begin
               if (key_wr_en) begin
                  r_wr_ptr <= r_wr_ptr + RW'(1);
                  if (r_wr_ptr == RW'(NR)) begin
                     r_state <= LOADED;
                  end
               end
            end
            LOADED: begin
               if (start) begin
                  r_state    <= RUN;
                  r_rd_round <= RW'(NR);
               end
            end
            RUN: begin
               if (w_accept) begin
                  // Round 0 ends the sequence; the index never wraps.
                  if (r_rd_round == '0) begin
                     r_state <= LOADED;
                  end else begin
                     r_rd_round <= r_rd_round - RW'(1);
                  end
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   assign keys_loaded = (r_state != EMPTY);
   assign busy        = (r_state == RUN);
   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_round   = r_out_round;
   assign out_last    = r_out_last;

endmodule

// File: tb/tb_inv_round_key_sequencer.sv
// tb/tb_inv_round_key_sequencer.sv - self-checking bench for inv_round_key_sequencer
module tb_inv_round_key_sequencer;

   typedef struct packed {
      logic [127:0] d;
      logic [3:0]   r;
      logic         l;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         key_wr_en;
   logic [127:0] key_wr_data;
   logic         key_clear;
   logic         keys_loaded;
   logic         start;
   logic         busy;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_round;
   logic         out_last;

   int           checks = 0;
   int           errors = 0;
   int           n_out  = 0;
   int           model_round = 0;
   logic [127:0] model_key [0:10];
   exp_t         sb [$];

   inv_round_key_sequencer #(.WIDTH(128), .NR(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_wr_en   (key_wr_en),
      .key_wr_data (key_wr_data),
      .key_clear   (key_clear),
      .keys_loaded (keys_loaded),
      .start       (start),
      .busy        (busy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_round   (out_round),
      .out_last    (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chke(input string tag, input exp_t obs, input exp_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h/r%0d/l%b expected=%h/r%0d/l%b",
                tag, obs.d, obs.r, obs.l, exp.d, exp.r, exp.l);
      end
   endtask

   // Scoreboard: pop on output transfers, push on input transfers (sampled mid-cycle).
   always @(negedge clk) begin
      if (!rst && !key_clear) begin
         if (out_valid && out_ready) begin
            chk1("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               chke("sb_beat", {out_data, out_round, out_last}, sb.pop_front());
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            sb.push_back({in_data ^ model_key[model_round], 4'(model_round), model_round == 0});
            model_round--;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_key(input logic [127:0] d);
      key_wr_en   = 1'b1;
      key_wr_data = d;
      step();
      key_wr_en   = 1'b0;
   endtask

   task automatic wait_round(input logic [3:0] rnd);
      int n = 0;
      step();
      while (!(out_valid && out_round == rnd) && n < 40) begin
         step();
         n++;
      end
      chk1("wait_round_in_budget", n < 40, 1'b1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk1({tag, "_in_ready"},    in_ready,    1'b0);
      chk1({tag, "_out_valid"},   out_valid,   1'b0);
      chkd({tag, "_out_data"},    out_data,    128'h0);
      chk4({tag, "_out_round"},   out_round,   4'd0);
      chk1({tag, "_out_last"},    out_last,    1'b0);
      chk1({tag, "_keys_loaded"}, keys_loaded, 1'b0);
      chk1({tag, "_busy"},        busy,        1'b0);
   endtask

   initial begin
      logic [127:0] hold_d;
      logic [3:0]   hold_r;
      logic [7:0]   b;

      rst = 1'b1; key_wr_en = 1'b0; key_wr_data = '0; key_clear = 1'b0;
      start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      for (int r = 0; r <= 10; r++) begin
         b = 8'h10 + 8'(r);
         model_key[r] = {16{b}};
      end

      #2;
      chk_reset_values("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Early start after only five keys
      for (int r = 0; r < 5; r++) write_key(model_key[r]);
      start = 1'b1; step(); start = 1'b0;
      chk1("early_start_busy", busy, 1'b0);
      chk1("early_start_in_ready", in_ready, 1'b0);
      chk1("early_keys_loaded", keys_loaded, 1'b0);

      // Remaining keys; start coinciding with the final write is ignored
      for (int r = 5; r < 10; r++) write_key(model_key[r]);
      start = 1'b1;
      write_key(model_key[10]);
      start = 1'b0;
      chk1("final_write_keys_loaded", keys_loaded, 1'b1);
      chk1("final_write_start_ignored", busy, 1'b0);
      write_key({128{1'b1}});
      chk1("overflow_keys_loaded", keys_loaded, 1'b1);
      chk1("overflow_busy", busy, 1'b0);

      // Basic decrypt order with backpressure at round 7
      start = 1'b1; model_round = 10; step(); start = 1'b0;
      chk1("start_busy", busy, 1'b1);
      chk1("start_in_ready", in_ready, 1'b1);
      n_out = 0;
      in_valid = 1'b1; in_data = {16{8'hCB}}; out_ready = 1'b1;
      wait_round(4'd10);
      chkd("first_out_data", out_data, {16{8'hD1}});
      wait_round(4'd7);
      out_ready = 1'b0;
      #1;
      chk1("bp_in_ready", in_ready, 1'b0);
      hold_d = out_data;
      hold_r = out_round;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("bp_out_valid", out_valid, 1'b1);
         chkd("bp_out_data", out_data, hold_d);
         chk4("bp_out_round", out_round, hold_r);
         chk1("bp_in_ready_hold", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      wait_round(4'd0);
      chk1("last_busy_fell", busy, 1'b0);
      chk1("last_out_last", out_last, 1'b1);
      chkd("last_out_data", out_data, {16{8'hDB}});

      // Back-to-back block reusing the retained keys
      in_valid = 1'b0;
      start = 1'b1; model_round = 10; step(); start = 1'b0;
      chk1("b2b_busy", busy, 1'b1);
      chk1("run1_beat_count", n_out == 11, 1'b1);
      n_out = 0;
      in_valid = 1'b1; in_data = {16{8'h00}};
      wait_round(4'd10);
      chkd("b2b_first_data", out_data, {16{8'h1A}});
      wait_round(4'd0);
      chk1("b2b_out_last", out_last, 1'b1);
      in_valid = 1'b0;
      step();
      chk1("b2b_drained", out_valid, 1'b0);
      chk1("b2b_sb_empty", sb.size() == 0, 1'b1);
      chk1("run2_beat_count", n_out == 11, 1'b1);

      // Clear mid-run at round 6
      start = 1'b1; model_round = 10; step(); start = 1'b0;
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      wait_round(4'd6);
      key_clear = 1'b1; step(); key_clear = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk1("clear_busy", busy, 1'b0);
      chk1("clear_out_valid", out_valid, 1'b0);
      chk1("clear_keys_loaded", keys_loaded, 1'b0);
      chk1("clear_in_ready", in_ready, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      chk1("clear_start_ignored", busy, 1'b0);
      chk1("clear_start_in_ready", in_ready, 1'b0);

      // Reload and reset asynchronously at round 4
      for (int r = 0; r <= 10; r++) write_key(model_key[r]);
      chk1("reload_keys_loaded", keys_loaded, 1'b1);
      start = 1'b1; model_round = 10; step(); start = 1'b0;
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      wait_round(4'd4);
      #2 rst = 1'b1;
      #1;
      chk_reset_values("async_rst");
      sb.delete();
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk1("post_rst_keys_loaded", keys_loaded, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_round_key_sequencer.md
# inv_round_key_sequencer

Decrypt-side round-key sequencer for the AES-128 datapath. Round keys are written in expansion order (round 0 … NR) and held in a local key buffer. On `start`, the block reads them back in reverse order (NR … 0) and XORs each one onto the incoming cipher state through the `addRoundKey` XOR stage. It sits between the key-expansion unit (the writer) and the inverse round datapath (the consumer), and throttles state beats with a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 128: state and round-key width in bits.
- `NR`, 10: number of rounds; the buffer holds NR+1 keys.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_wr_en` in 1: write strobe for one round key.
- `key_wr_data` in WIDTH: round key; consecutive writes fill rounds 0 … NR in order.
- `key_clear` in 1: discard all keys and abort any run.
- `keys_loaded` out 1: all NR+1 keys present.
- `start` in 1: begin one decrypt key sequence.
- `busy` out 1: sequence in progress.
- `in_valid` in 1, `in_ready` out 1, `in_data` in WIDTH: state input handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out WIDTH: XORed state output.
- `out_round` out `$clog2(NR+1)`: round index of the key applied to `out_data`.
- `out_last` out 1: marks the beat that used the round-0 key.

## Operation
States:
- **EMPTY**
  - Each `key_wr_en` stores the key at `wr_ptr` and increments `wr_ptr`.
  - On the NR+1-th write, go to LOADED and set `keys_loaded` = 1.
  - `start` is ignored.
- **LOADED**
  - `key_wr_en` is ignored; keys are retained.
  - `start` → RUN with `rd_round` = NR.
- **RUN**
  - `busy` = 1.
  - `in_ready` = !`out_valid` || `out_ready`.
  - On each accepted beat:
    - `out_data` <= `in_data` ^ `key[rd_round]`
    - `out_round` <= `rd_round`
    - `out_last` <= (`rd_round` == 0)
  - After an accepted beat, `rd_round` decrements.
  - The beat with `rd_round` == 0 returns the FSM to LOADED.
  - `start` and `key_wr_en` are ignored while in RUN.

Handshake rules:
- `out_valid`, `out_data`, `out_round` and `out_last` hold stable while `out_valid` && !`out_ready`.
- `out_valid` clears when the output is consumed and no new beat is accepted in the same cycle.

Boundary conditions:
- `key_clear` has priority over every other input in any state. Next cycle: EMPTY, `wr_ptr` = 0, `keys_loaded` = 0, `busy` = 0, `out_valid` = 0. Buffer contents are don't-care.
- `key_clear` and `key_wr_en` in the same cycle: the write is dropped.
- `start` and the final key write in the same cycle: `start` is ignored.
- `rd_round` never wraps below 0. The FSM leaves RUN on the round-0 beat.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_round` 0, `out_last` 0, `keys_loaded` 0, `busy` 0. FSM in EMPTY, pointers 0.
- Latency from an accepted input beat to `out_valid` is 1 cycle. Throughput is one beat per cycle while `out_ready` = 1.
- `start` sampled in cycle t → `busy` and `in_ready` high in cycle t+1.
- Final key write in cycle t → `keys_loaded` = 1 in cycle t+1; `start` is accepted from cycle t+1.
- A full sequence is NR+1 beats, minimum NR+1 cycles after `start`.
- The round-0 beat is accepted in cycle t → `busy` = 0 in t+1, and `out_valid` with `out_last` = 1 in t+1.
- Asynchronous `rst` clears all state immediately, including mid-run.

## Structure
- `aes_pkg` holds:
  - `NR` = 10 and `STATE_W` = 128 constants
  - `state_t` (logic [127:0])
  - `round_idx_t` (logic [3:0])
  - the FSM enum `seq_state_e` {EMPTY, LOADED, RUN}
- Key buffer: a register array of NR+1 × WIDTH with a write pointer and a read index.
- The XOR is done by instantiating the existing `addRoundKey #(WIDTH)` block, fed by `in_data` and `key[rd_round]`. Its output is registered here.

## Test plan
- **Basic decrypt order:**
  - Stimulus: write key r = {16{8'h10+r}} for r = 0..10; pulse `start`; send 11 beats of `in_data` = {16{8'hCB}} with `out_ready` = 1.
  - Response: first output has `out_round` 10 and `out_data` {16{8'hD1}}.
  - Response: last output has `out_round` 0, `out_data` {16{8'hDB}}, `out_last` = 1.
  - Response: `busy` falls the cycle after the last beat is accepted.
- **Backpressure:**
  - Stimulus: hold `out_ready` = 0 for 3 cycles at round 7.
  - Response: `out_data`/`out_round` stay stable and `in_ready` = 0.
  - Response: after release, the rounds continue 6, 5, … with no round skipped or repeated.
- **Early start and overflow write:**
  - Stimulus: write 5 keys, pulse `start`. Response: `busy` and `in_ready` stay 0.
  - Stimulus: complete 11 writes, then issue a 12th write of all-ones. Response: key 10 is unchanged, as checked by a following run.
- **Clear mid-run:**
  - Stimulus: assert `key_clear` while at round 6.
  - Response: next cycle `busy` = 0, `out_valid` = 0, `keys_loaded` = 0, `in_ready` = 0.
  - Response: a subsequent `start` is ignored.
- **Async reset mid-run:**
  - Stimulus: assert `rst` between clock edges at round 4.
  - Response: all outputs at reset values before the next edge.
  - Response: after release, `keys_loaded` = 0.
- **Back-to-back blocks:**
  - Stimulus: after `out_last`, pulse `start` again and send {16{8'h00}}.
  - Response: first output is {16{8'h1A}} with `out_round` 10, proving the keys were retained.
